// File: rtl/pixel_pkg.sv
// pixel_pkg: shared state encoding, default geometry and row-index width helper for the pixel frame controller
package pixel_pkg;
  typedef enum logic [2:0] {IDLE, ERASE, EXPOSE, CONVERT, RSEL, RWAIT} state_t;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ROWS = 2;
  localparam int DEF_COLS = 2;
  function automatic int row_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/ramp_counter.sv
// ramp_counter: W-bit up counter with sync clear, enable and terminal-count flag
module ramp_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);
  logic [W-1:0] cnt_q;
  // count while enabled, clear dominates
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i) cnt_q <= cnt_q + 1'b1;
  assign cnt_o = cnt_q;
  assign tc_o = &cnt_q;
endmodule

// File: rtl/pixel_frame_ctrl.sv
// pixel_frame_ctrl: global-shutter erase/expose/convert/readout sequencer with valid/ready row stream
module pixel_frame_ctrl
  import pixel_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS,
  parameter int ERASE_CYCLES = 4,
  parameter int EXP_W = 16,
  localparam int RW = row_w(ROWS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   continuous,
  input  logic [EXP_W-1:0]       expose_cycles,
  output logic                   busy,
  output logic                   pix_erase,
  output logic                   pix_expose,
  output logic                   pix_convert,
  output logic                   col_drive_en,
  output logic [DATA_W-1:0]      dig_ramp,
  output logic [ROWS-1:0]        row_read,
  input  logic [COLS*DATA_W-1:0] col_data,
  output logic [COLS*DATA_W-1:0] out_data,
  output logic [RW-1:0]          out_row,
  output logic                   out_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   frame_done
);
  state_t state_q;
  logic [EXP_W-1:0] tmr_q, exp_q, exp_last;
  logic [RW-1:0] r_q;
  logic ramp_tc;
  assign exp_last = (exp_q == '0) ? '0 : exp_q - 1'b1;
  ramp_counter #(.W(DATA_W)) u_ramp (
    .clk(clk),
    .reset(reset),
    .clr_i(state_q != CONVERT),
    .en_i(state_q == CONVERT),
    .cnt_o(dig_ramp),
    .tc_o(ramp_tc)
  );
  // frame sequencer with phase timer, row index and readout stream registers
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      tmr_q <= '0;
      exp_q <= '0;
      r_q <= '0;
      out_data <= '0;
      out_row <= '0;
      out_last <= 1'b0;
      out_valid <= 1'b0;
    end else
      case (state_q)
        IDLE:
          if (start) begin
            state_q <= ERASE;
            exp_q <= expose_cycles;
            tmr_q <= '0;
          end
        ERASE:
          if (tmr_q == EXP_W'(ERASE_CYCLES - 1)) begin
            state_q <= EXPOSE;
            tmr_q <= '0;
          end else tmr_q <= tmr_q + 1'b1;
        EXPOSE:
          if (tmr_q == exp_last) begin
            state_q <= CONVERT;
            tmr_q <= '0;
          end else tmr_q <= tmr_q + 1'b1;
        CONVERT:
          if (ramp_tc) begin
            state_q <= RSEL;
            r_q <= '0;
          end
        RSEL: begin
          out_data <= col_data;
          out_row <= r_q;
          out_last <= (r_q == RW'(ROWS - 1));
          out_valid <= 1'b1;
          state_q <= RWAIT;
        end
        RWAIT:
          if (out_ready) begin
            out_valid <= 1'b0;
            if (!out_last) begin
              r_q <= r_q + 1'b1;
              state_q <= RSEL;
            end else begin
              r_q <= '0;
              tmr_q <= '0;
              exp_q <= expose_cycles;
              state_q <= continuous ? ERASE : IDLE;
            end
          end
        default: state_q <= IDLE;
      endcase
  assign busy = state_q != IDLE;
  assign pix_erase = state_q == ERASE;
  assign pix_expose = state_q == EXPOSE;
  assign pix_convert = state_q == CONVERT;
  assign col_drive_en = pix_convert;
  assign row_read = (state_q == RSEL) ? ROWS'(1) << r_q : '0;
  assign frame_done = (state_q == RWAIT) && out_ready && out_last;
endmodule

// File: tb/tb_pixel_frame_ctrl.sv
// tb_pixel_frame_ctrl: randomized directed bench with a phase-length/scoreboard reference model
module tb_pixel_frame_ctrl;
  localparam int DW = 8, ROWS = 2, COLS = 2, EC = 4;
  int checks = 0, errors = 0;
  logic clk = 1'b0;
  logic reset, start, continuous, out_ready;
  logic [15:0] expose_cycles;
  logic [COLS*DW-1:0] col_data, out_data;
  logic busy, pix_erase, pix_expose, pix_convert, col_drive_en, out_last, out_valid, frame_done;
  logic [DW-1:0] dig_ramp;
  logic [ROWS-1:0] row_read;
  logic [0:0] out_row;
  logic start2, ready2;
  logic [15:0] exp2;
  logic [3:0] col2, out_data2, ramp2;
  logic busy2, erase2, expose2, convert2, cde2, last2, valid2, done2;
  logic [2:0] row_read2;
  logic [1:0] out_row2;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  pixel_frame_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .continuous(continuous), .expose_cycles(expose_cycles),
    .busy(busy), .pix_erase(pix_erase), .pix_expose(pix_expose), .pix_convert(pix_convert),
    .col_drive_en(col_drive_en), .dig_ramp(dig_ramp), .row_read(row_read), .col_data(col_data),
    .out_data(out_data), .out_row(out_row), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .frame_done(frame_done)
  );
  pixel_frame_ctrl #(.DATA_W(4), .ROWS(3), .COLS(1)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .continuous(1'b0), .expose_cycles(exp2),
    .busy(busy2), .pix_erase(erase2), .pix_expose(expose2), .pix_convert(convert2),
    .col_drive_en(cde2), .dig_ramp(ramp2), .row_read(row_read2), .col_data(col2),
    .out_data(out_data2), .out_row(out_row2), .out_last(last2), .out_valid(valid2),
    .out_ready(ready2), .frame_done(done2)
  );
  task automatic kick();
    @(negedge clk) start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
  endtask
  task automatic frame(input int e, input int mode, input bit chg_exp, input int glitch, input int drop, output int len);
    int er = 0, ex = 0, cv = 0, rbad = 0, dbad = 0, nxt = 0, got = 0, stl = 0, rdy;
    logic [COLS*DW-1:0] vals [ROWS];
    len = -1;
    for (int r = 0; r < ROWS; r++) vals[r] = (mode == 0) ? {COLS{DW'(r * 8'h11 + 1)}} : (COLS*DW)'($urandom);
    for (int n = 1; n <= 2000; n++) begin
      @(negedge clk);
      if (n == 100) start = 1'b1;
      if (n == 101) start = 1'b0;
      if (glitch != 0 && n == glitch) continuous = 1'b0;
      if (glitch != 0 && n == glitch + 1) continuous = 1'b1;
      if (drop != 0 && n == drop) continuous = 1'b0;
      er += int'(pix_erase);
      ex += int'(pix_expose);
      if (pix_expose && chg_exp) expose_cycles = 16'd50;
      if (pix_convert) begin
        if (dig_ramp !== DW'(cv) || !col_drive_en) rbad++;
        cv++;
      end else if (dig_ramp !== '0 || col_drive_en) rbad++;
      col_data = (COLS*DW)'($urandom);
      if (row_read !== '0) begin
        if (nxt >= ROWS || row_read !== ROWS'(1) << nxt || out_valid) rbad++;
        else col_data = vals[nxt];
      end
      if (out_valid) begin
        if (got >= ROWS || out_data !== vals[got] || out_row !== 1'(got) || out_last !== (got == ROWS - 1) || row_read !== '0) dbad++;
        rdy = (mode == 1) ? int'($urandom_range(0, 1)) : (mode == 2 && got == 0 && stl < 5) ? 0 : 1;
        out_ready = rdy[0];
        if (rdy == 0) stl++;
        else begin got++; nxt++; end
      end else out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (frame_done) begin len = n; break; end
    end
    @(posedge clk) #1;
    chk("erase_width", er, EC);
    chk("expose_width", ex, (e == 0) ? 1 : e);
    chk("convert_width", cv, 1 << DW);
    chk("ramp_rowsel", rbad, 0);
    chk("row_data", dbad, 0);
    chk("rows_emitted", got, ROWS);
    chk("frame_len", len, EC + ((e == 0) ? 1 : e) + (1 << DW) + 2 * ROWS + stl);
  endtask
  initial begin
    int len, n2, len2, cv2, got2;
    int rq[$];
    int oq[$];
    int lq[$];
    bit found;
    reset = 1'b1; start = 1'b0; continuous = 1'b0; out_ready = 1'b1; expose_cycles = '0; col_data = '0;
    start2 = 1'b0; ready2 = 1'b1; exp2 = 16'd3; col2 = '0;
    repeat (2) @(negedge clk);
    chk("reset_outs", {busy, pix_erase, pix_expose, pix_convert, col_drive_en, dig_ramp, row_read, out_data, out_row, out_last, out_valid, frame_done}, '0);
    chk("reset_outs2", {busy2, erase2, expose2, convert2, cde2, ramp2, row_read2, out_data2, out_row2, last2, valid2, done2}, '0);
    reset = 1'b0;
    expose_cycles = 16'd10; kick(); frame(10, 0, 0, 0, 0, len);
    chk("single_len", len, 274);
    chk("single_idle", busy, 1'b0);
    kick(); frame(10, 2, 0, 0, 0, len);
    chk("bp_len", len, 279);
    expose_cycles = 16'd0; kick(); frame(0, 1, 0, 0, 0, len);
    expose_cycles = 16'd20; kick(); frame(20, 1, 1, 0, 0, len);
    continuous = 1'b1; expose_cycles = 16'd7; kick();
    frame(7, 1, 0, 30, 0, len);
    chk("cont_erase1", pix_erase, 1'b1);
    frame(7, 1, 0, 0, 0, len);
    chk("cont_erase2", pix_erase, 1'b1);
    frame(7, 1, 0, 0, 50, len);
    chk("cont_end_idle", busy, 1'b0);
    repeat (5) @(negedge clk);
    chk("cont_stay_idle", {busy, pix_erase}, 2'b00);
    for (int k = 0; k < 3; k++) begin
      expose_cycles = 16'($urandom_range(0, 30));
      kick(); frame(int'(expose_cycles), 1, 0, 0, 0, len);
    end
    expose_cycles = 16'd5; out_ready = 1'b1; kick();
    found = 1'b0;
    for (int n = 0; n < 500 && !found; n++) begin
      @(negedge clk);
      found = pix_convert && dig_ramp == 8'h40;
    end
    chk("reach_ramp40", found, 1'b1);
    #2 reset = 1'b1;
    #1 chk("async_reset_outs", {busy, pix_erase, pix_expose, pix_convert, col_drive_en, dig_ramp, row_read, out_data, out_row, out_last, out_valid, frame_done}, '0);
    @(negedge clk) reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("post_reset_idle", busy, 1'b0);
    kick(); frame(5, 0, 0, 0, 0, len);
    @(negedge clk) start2 = 1'b1;
    @(posedge clk) #1 start2 = 1'b0;
    len2 = -1; cv2 = 0; got2 = 0;
    for (n2 = 1; n2 <= 300; n2++) begin
      @(negedge clk);
      cv2 += int'(convert2);
      col2 = 4'($urandom);
      if (row_read2 != 0) begin
        rq.push_back(int'(row_read2));
        for (int r = 0; r < 3; r++) if (row_read2[r]) col2 = 4'(r * 5 + 3);
      end
      if (valid2) begin
        oq.push_back(int'(out_row2));
        lq.push_back(int'(last2));
        if (out_data2 !== 4'(got2 * 5 + 3)) lq.push_back(9);
        got2++;
      end
      #1;
      if (done2) begin len2 = n2; break; end
    end
    chk("p_convert", cv2, 16);
    chk("p_len", len2, 4 + 3 + 16 + 6);
    chk("p_rowsel_n", rq.size(), 3);
    chk("p_rowsel", (rq.size() == 3) ? {rq[0][2:0], rq[1][2:0], rq[2][2:0]} : 9'h0, 9'b001_010_100);
    chk("p_outrow_n", oq.size(), 3);
    chk("p_outrow", (oq.size() == 3) ? {oq[0][1:0], oq[1][1:0], oq[2][1:0]} : 6'h3f, 6'b00_01_10);
    chk("p_last_data", (lq.size() == 3) ? {lq[0][0], lq[1][0], lq[2][0]} : 3'b111, 3'b001);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
